// File: rtl/ap_isa_pkg.sv
// Shared definitions for the instruction-cache burst path: reader FSM encodings,
// the default burst limit and the instruction-cache opcode constants.
package ap_isa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd1,
    ST_REQ  = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } isa_rd_state_e;

  localparam int MAX_BURST_LEN_DEF = 128;

  localparam logic [3:0] OP_ICACHE_NOP   = 4'h0;
  localparam logic [3:0] OP_ICACHE_FILL  = 4'h1;
  localparam logic [3:0] OP_ICACHE_INVAL = 4'h2;
  localparam logic [3:0] OP_ICACHE_FLUSH = 4'h3;

  function automatic logic [9:0] clamp_len(input logic [9:0] len, input logic [9:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/isa_burst_reader.sv
// Fetches a burst of instructions from DDR for the instruction cache, one
// instruction per read beat, with short-burst / misalignment / oversize flagging.
module isa_burst_reader
  import ap_isa_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int ISA_WIDTH      = 30,
  parameter int MAX_BURST_LEN  = MAX_BURST_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ISA_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
  input  logic [9:0]                isa_read_len,
  output logic [ISA_WIDTH-1:0]      instruction_to_cache,
  output logic [9:0]                rd_cnt_isa,
  output logic                      rd_burst_data_valid,
  output logic                      isa_read_done,
  output logic                      isa_read_err,
  output logic                      ddr_rd_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  output logic [9:0]                ddr_rd_len,
  input  logic [DDR_DATA_WIDTH-1:0] ddr_rd_data,
  input  logic                      ddr_rd_data_valid,
  input  logic                      ddr_rd_finish,
  output logic [2:0]                st_cur_isa_rd
);

  localparam logic [9:0] MAX_LEN = 10'(MAX_BURST_LEN);

  isa_rd_state_e             state_q, state_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [9:0]                len_q, len_d;
  logic [9:0]                cnt_q, cnt_d;
  logic [ISA_WIDTH-1:0]      instr_q, instr_d;
  logic                      strobe_q, strobe_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      req_q, req_d;
  logic                      beat_ok_s;
  logic [9:0]                cnt_inc_s;
  logic                      unused_s;

  assign unused_s = ^ddr_rd_data;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    strobe_d = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
    req_d    = req_q;
    // Beats past the latched length are dropped, which also saturates the count.
    beat_ok_s = ddr_rd_data_valid && (cnt_q < len_q);
    cnt_inc_s = beat_ok_s ? (cnt_q + 10'd1) : cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (ISA_read_req) begin
          addr_d = {ISA_read_addr[DDR_ADDR_WIDTH-1:3], 3'b000};
          len_d  = clamp_len(isa_read_len, MAX_LEN);
          cnt_d  = 10'd0;
          err_d  = (ISA_read_addr[2:0] != 3'b000) || (isa_read_len > MAX_LEN);
          if (isa_read_len == 10'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ, ST_DATA: begin
        if (beat_ok_s) begin
          instr_d  = ddr_rd_data[ISA_WIDTH-1:0];
          cnt_d    = cnt_inc_s;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
        if (ddr_rd_data_valid) begin
          req_d = 1'b0;
          if (state_q == ST_REQ) state_d = ST_DATA;
          else state_d = state_q;
        end else begin
          req_d = req_q;
        end
        // A beat arriving with finish is already folded into cnt_inc_s.
        if (ddr_rd_finish) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          req_d   = 1'b0;
          if (cnt_inc_s < len_q) err_d = 1'b1;
          else err_d = err_q;
        end else begin
          done_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (!ISA_read_req) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= 10'd0;
      cnt_q    <= 10'd0;
      instr_q  <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      req_q    <= req_d;
    end
  end

  assign instruction_to_cache = instr_q;
  assign rd_cnt_isa           = cnt_q;
  assign rd_burst_data_valid  = strobe_q;
  assign isa_read_done        = done_q;
  assign isa_read_err         = err_q;
  assign ddr_rd_req           = req_q;
  assign ddr_rd_addr          = addr_q;
  assign ddr_rd_len           = len_q;
  assign st_cur_isa_rd        = state_q;

endmodule

// File: tb/tb_isa_burst_reader.sv
// Directed bench for isa_burst_reader: nominal burst, overrun, short burst,
// misaligned/oversize request, mid-burst reset and zero-length request.
module tb_isa_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ISA_read_req;
  logic [27:0] ISA_read_addr;
  logic [9:0]  isa_read_len;
  logic [29:0] instruction_to_cache;
  logic [9:0]  rd_cnt_isa;
  logic        rd_burst_data_valid;
  logic        isa_read_done;
  logic        isa_read_err;
  logic        ddr_rd_req;
  logic [27:0] ddr_rd_addr;
  logic [9:0]  ddr_rd_len;
  logic [63:0] ddr_rd_data;
  logic        ddr_rd_data_valid;
  logic        ddr_rd_finish;
  logic [2:0]  st_cur_isa_rd;

  int tests = 0;
  int fails = 0;
  int strobes;

  isa_burst_reader dut (
    .clk(clk), .rst(rst),
    .ISA_read_req(ISA_read_req), .ISA_read_addr(ISA_read_addr), .isa_read_len(isa_read_len),
    .instruction_to_cache(instruction_to_cache), .rd_cnt_isa(rd_cnt_isa),
    .rd_burst_data_valid(rd_burst_data_valid), .isa_read_done(isa_read_done),
    .isa_read_err(isa_read_err), .ddr_rd_req(ddr_rd_req), .ddr_rd_addr(ddr_rd_addr),
    .ddr_rd_len(ddr_rd_len), .ddr_rd_data(ddr_rd_data), .ddr_rd_data_valid(ddr_rd_data_valid),
    .ddr_rd_finish(ddr_rd_finish), .st_cur_isa_rd(st_cur_isa_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d);
    ddr_rd_data       = d;
    ddr_rd_data_valid = 1'b1;
    tick();
    ddr_rd_data_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ISA_read_req = 1'b0; ISA_read_addr = 28'h0; isa_read_len = 10'd0;
    ddr_rd_data = 64'h0; ddr_rd_data_valid = 1'b0; ddr_rd_finish = 1'b0;
    tick(); tick();
    chk("rst_state", st_cur_isa_rd, 3'd1);
    chk("rst_cnt", rd_cnt_isa, 10'd0);
    chk("rst_req", ddr_rd_req, 1'b0);
    chk("rst_done_err", {isa_read_done, isa_read_err, rd_burst_data_valid}, 3'b000);
    rst = 1'b0;
    tick();

    // Nominal 4-instruction burst, upper data bits must be stripped
    ISA_read_req = 1'b1; ISA_read_addr = 28'h40; isa_read_len = 10'd4;
    tick();
    chk("s1_state_req", st_cur_isa_rd, 3'd2);
    chk("s1_ddr_req", ddr_rd_req, 1'b1);
    chk("s1_ddr_addr", ddr_rd_addr, 28'h40);
    chk("s1_ddr_len", ddr_rd_len, 10'd4);
    tick();
    chk("s1_req_stall", ddr_rd_req, 1'b1);
    for (int i = 0; i < 4; i++) begin
      beat(64'hFFFF_0000_0000_000A + 64'(i));
      chk("s1_strobe", rd_burst_data_valid, 1'b1);
      chk("s1_cnt", rd_cnt_isa, 10'(i + 1));
      chk("s1_instr", instruction_to_cache, 30'hA + 30'(i));
      chk("s1_ddr_req_drop", ddr_rd_req, 1'b0);
    end
    chk("s1_state_data", st_cur_isa_rd, 3'd3);
    ddr_rd_finish = 1'b1;
    tick();
    ddr_rd_finish = 1'b0;
    chk("s1_done", isa_read_done, 1'b1);
    chk("s1_state_done", st_cur_isa_rd, 3'd4);
    chk("s1_err", isa_read_err, 1'b0);
    chk("s1_cnt_final", rd_cnt_isa, 10'd4);
    tick();
    chk("s1_done_hold", {isa_read_done, ddr_rd_req}, 2'b10);
    ISA_read_req = 1'b0;
    tick();
    chk("s1_idle", st_cur_isa_rd, 3'd1);
    chk("s1_done_clear", isa_read_done, 1'b0);

    // Overrun: 5 beats for len 3
    ISA_read_req = 1'b1; ISA_read_addr = 28'h100; isa_read_len = 10'd3;
    tick();
    strobes = 0;
    for (int i = 1; i <= 5; i++) begin
      beat(64'(i));
      if (rd_burst_data_valid) strobes++;
    end
    chk("s2_strobes", 64'(strobes), 64'd3);
    chk("s2_cnt", rd_cnt_isa, 10'd3);
    chk("s2_instr", instruction_to_cache, 30'h3);
    ddr_rd_finish = 1'b1;
    tick();
    ddr_rd_finish = 1'b0;
    chk("s2_done_err", {isa_read_done, isa_read_err}, 2'b10);
    ISA_read_req = 1'b0;
    tick();

    // Short burst: len 8, finish arrives together with beat 5
    ISA_read_req = 1'b1; ISA_read_addr = 28'h200; isa_read_len = 10'd8;
    tick();
    for (int i = 1; i <= 4; i++) beat(64'h50 + 64'(i));
    ddr_rd_finish = 1'b1;
    beat(64'h55);
    ddr_rd_finish = 1'b0;
    chk("s3_cnt", rd_cnt_isa, 10'd5);
    chk("s3_strobe_last", rd_burst_data_valid, 1'b1);
    chk("s3_instr", instruction_to_cache, 30'h55);
    chk("s3_state_done", st_cur_isa_rd, 3'd4);
    chk("s3_err", isa_read_err, 1'b1);
    beat(64'h99);
    chk("s3_done_no_strobe", {rd_burst_data_valid, rd_cnt_isa}, {1'b0, 10'd5});
    ISA_read_req = 1'b0;
    tick();
    chk("s3_err_sticky", isa_read_err, 1'b1);

    // Misaligned, oversize; request dropped mid-burst must not abort
    ISA_read_req = 1'b1; ISA_read_addr = 28'h43; isa_read_len = 10'd200;
    tick();
    chk("s4_addr", ddr_rd_addr, 28'h40);
    chk("s4_len", ddr_rd_len, 10'd128);
    chk("s4_err", isa_read_err, 1'b1);
    ISA_read_req = 1'b0;
    tick();
    chk("s4_no_abort", st_cur_isa_rd, 3'd2);
    ddr_rd_finish = 1'b1;
    tick();
    ddr_rd_finish = 1'b0;
    chk("s4_done", {st_cur_isa_rd, rd_cnt_isa}, {3'd4, 10'd0});
    tick();
    chk("s4_idle", st_cur_isa_rd, 3'd1);

    // Fresh acceptance clears the error
    ISA_read_req = 1'b1; ISA_read_addr = 28'h80; isa_read_len = 10'd6;
    tick();
    chk("s5_err_clear", isa_read_err, 1'b0);
    beat(64'h61);
    beat(64'h62);
    chk("s5_cnt_pre", rd_cnt_isa, 10'd2);
    rst = 1'b1;
    #1;
    chk("s5_async_state", st_cur_isa_rd, 3'd1);
    chk("s5_async_outs", {rd_cnt_isa, instruction_to_cache, ddr_rd_req, isa_read_done}, 42'd0);
    tick();
    ISA_read_req = 1'b0;
    rst = 1'b0;
    strobes = 0;
    for (int i = 3; i <= 6; i++) begin
      beat(64'h60 + 64'(i));
      if (rd_burst_data_valid) strobes++;
    end
    chk("s5_post_strobes", 64'(strobes), 64'd0);
    chk("s5_post_cnt", {st_cur_isa_rd, rd_cnt_isa, ddr_rd_addr}, {3'd1, 10'd0, 28'h0});

    // Zero-length request goes straight to DONE
    ISA_read_req = 1'b1; ISA_read_addr = 28'h300; isa_read_len = 10'd0;
    tick();
    chk("s6_state", st_cur_isa_rd, 3'd4);
    chk("s6_done", isa_read_done, 1'b1);
    chk("s6_cnt_req", {rd_cnt_isa, ddr_rd_req}, 11'd0);
    tick();
    chk("s6_req_never", ddr_rd_req, 1'b0);
    ISA_read_req = 1'b0;
    tick();
    chk("s6_idle", st_cur_isa_rd, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/isa_burst_reader.md
ISA_BURST_READER -- requirements
Module: isa_burst_reader

Interface
REQ-001 SHALL have parameter DDR_ADDR_WIDTH, default 28, DDR byte-address width.
REQ-002 SHALL have parameter DDR_DATA_WIDTH, default 64, DDR read beat width.
REQ-003 SHALL have parameter ISA_WIDTH, default 30, instruction width; ISA_WIDTH <= DDR_DATA_WIDTH.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 128, largest burst in beats.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ISA_read_req  in  1  level request from instruction cache, held until done observed.
REQ-008 ISA_read_addr  in  DDR_ADDR_WIDTH  byte address of first instruction, 8-byte aligned.
REQ-009 isa_read_len  in  10  instructions requested.
REQ-010 instruction_to_cache  out  ISA_WIDTH  fetched instruction.
REQ-011 rd_cnt_isa  out  10  instructions delivered this burst.
REQ-012 rd_burst_data_valid  out  1  one-cycle strobe per delivered instruction.
REQ-013 isa_read_done  out  1  high while in DONE.
REQ-014 isa_read_err  out  1  sticky: short burst, misalignment or oversize length.
REQ-015 ddr_rd_req  out  1  burst request to DDR controller.
REQ-016 ddr_rd_addr  out  DDR_ADDR_WIDTH  burst start address.
REQ-017 ddr_rd_len  out  10  burst length in beats.
REQ-018 ddr_rd_data  in  DDR_DATA_WIDTH  read beat.
REQ-019 ddr_rd_data_valid  in  1  beat valid.
REQ-020 ddr_rd_finish  in  1  one-cycle burst-complete pulse.
REQ-021 st_cur_isa_rd  out  3  current FSM state, debug.

Function
REQ-022 FSM states SHALL be IDLE=1, REQ=2, DATA=3, DONE=4.
REQ-023 IDLE: on ISA_read_req=1, latch addr (bits [2:0] forced 0) and len clamped to MAX_BURST_LEN, clear rd_cnt_isa and isa_read_err, go REQ; len=0 goes directly to DONE.
REQ-024 Misaligned address (bits [2:0]!=0) or len>MAX_BURST_LEN SHALL set isa_read_err at acceptance; transfer proceeds with forced/clamped values.
REQ-025 REQ: ddr_rd_req=1 with ddr_rd_addr/ddr_rd_len stable; drops in the cycle after the first ddr_rd_data_valid; go DATA on that beat.
REQ-026 Each ddr_rd_data_valid beat with count < latched len SHALL register instruction_to_cache=ddr_rd_data[ISA_WIDTH-1:0], increment rd_cnt_isa and pulse rd_burst_data_valid, all visible 1 cycle after the beat.
REQ-027 Beats beyond latched len SHALL be discarded: no strobe, no count change.
REQ-028 ddr_rd_finish in REQ or DATA SHALL go DONE; if count < len at that point, set isa_read_err.
REQ-029 Beat and finish in same cycle: the beat SHALL be counted before DONE is entered.
REQ-030 DONE: rd_cnt_isa and instruction_to_cache hold; isa_read_done=1; return to IDLE when ISA_read_req=0; no new burst while request stays high.
REQ-031 rd_cnt_isa SHALL saturate at latched len, never wrap.
REQ-032 ISA_read_req falling in REQ or DATA SHALL NOT abort; burst completes to DONE, then IDLE.

Reset
REQ-033 rst=1 SHALL force immediately: state IDLE, all outputs 0, latched addr/len/count 0.
REQ-034 Reset mid-burst SHALL abandon the burst; beats arriving after release in IDLE SHALL be ignored.

Structure
REQ-035 State encodings and MAX_BURST_LEN default SHALL live in shared package ap_isa_pkg with ins_cache opcode constants.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 len=4, addr=0x40, 4 beats 0xA..0xD then finish -> ddr_rd_addr=0x40, ddr_rd_len=4, 4 strobes, rd_cnt_isa 1..4, done=1, err=0.
REQ-038 len=3, 5 beats -> 3 strobes, rd_cnt_isa=3, last instruction=beat 3.
REQ-039 len=8, finish after 5 beats -> rd_cnt_isa=5, DONE, isa_read_err=1.
REQ-040 addr=0x43, len=200 -> ddr_rd_addr=0x40, ddr_rd_len=128, err=1.
REQ-041 rst pulse after beat 2 of 6 -> outputs 0 next cycle, IDLE, remaining beats no strobe.
REQ-042 len=0 -> DONE next cycle, rd_cnt_isa=0, ddr_rd_req never asserted.
